// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame edge numbers and the parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_XFER,
    ST_IDLE_WAIT
  } state_e;

  // Device falling-edge numbers within one host-to-device frame
  localparam logic [3:0] PS2_PAR_EDGE  = 4'd9;
  localparam logic [3:0] PS2_STOP_EDGE = 4'd10;
  localparam logic [3:0] PS2_ACK_EDGE  = 4'd11;

  // Odd parity: data plus parity bit carry an odd number of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on clock and data, a glitch
// filter on the clock line and a one-cycle pulse on each filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_sync,
  output logic ps2d_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          c_meta;
  logic          d_meta;
  logic          c_filt;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Lines idle high, so the synchronisers reset high to avoid a false edge
      c_meta    <= 1'b1;
      ps2c_sync <= 1'b1;
      d_meta    <= 1'b1;
      ps2d_sync <= 1'b1;
      c_filt    <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      c_meta    <= ps2c_in;
      ps2c_sync <= c_meta;
      d_meta    <= ps2d_in;
      ps2d_sync <= d_meta;
      fall      <= 1'b0;
      if (ps2c_sync != c_filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          c_filt <= ps2c_sync;
          cnt    <= '0;
          fall   <= c_filt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts
// one command byte out on device clock edges and checks the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8,
  parameter int IDLE_CYCLES    = 1250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > IDLE_CYCLES) ? INHIBIT_CYCLES : IDLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);

  logic c_sync;
  logic d_sync;
  logic fall;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_sync(c_sync),
    .ps2d_sync(d_sync),
    .fall     (fall)
  );

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WW-1:0] wdog, wdog_n;
  logic [3:0]    n, n_n;
  logic [7:0]    data, data_n;
  logic          par, par_n;
  logic          c_oe_n, d_oe_n, busy_n, done_n, error_n;
  logic          abort;
  logic          wdog_hit;
  logic [3:0]    n_inc;

  assign wdog_hit = (wdog == WW'(TIMEOUT_CYCLES - 1));
  assign n_inc    = n + 4'd1;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wdog_n  = wdog;
    n_n     = n;
    data_n  = data;
    par_n   = par;
    c_oe_n  = ps2c_oe;
    d_oe_n  = ps2d_oe;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    error_n = 1'b0;
    abort   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (tx_start) begin
          data_n  = tx_data;
          par_n   = odd_parity(tx_data);
          cnt_n   = '0;
          c_oe_n  = 1'b1;
          busy_n  = 1'b1;
          state_n = ST_INHIBIT;
        end
      end

      // The REQ cycle also holds the clock low, so INHIBIT is one cycle
      // shorter and ps2c_oe stays high for INHIBIT_CYCLES in total.
      ST_INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 2)) begin
          cnt_n   = '0;
          d_oe_n  = 1'b1;
          state_n = ST_REQ;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_REQ: begin
        c_oe_n  = 1'b0;
        n_n     = '0;
        wdog_n  = '0;
        state_n = ST_XFER;
      end

      ST_XFER: begin
        if (fall) begin
          wdog_n = '0;
          n_n    = n_inc;
          if (n_inc <= 4'd8) begin
            d_oe_n = ~data[n[2:0]];
          end else if (n_inc == PS2_PAR_EDGE) begin
            d_oe_n = ~par;
          end else if (n_inc == PS2_STOP_EDGE) begin
            d_oe_n = 1'b0;
          end else if (!d_sync) begin
            cnt_n   = '0;
            state_n = ST_IDLE_WAIT;
          end else begin
            abort = 1'b1;
          end
        end else if (wdog_hit) begin
          abort = 1'b1;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end

      ST_IDLE_WAIT: begin
        if (wdog_hit) begin
          abort = 1'b1;
        end else begin
          wdog_n = wdog + 1'b1;
          if (c_sync && d_sync) begin
            if (cnt == CW'(IDLE_CYCLES - 1)) begin
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = ST_IDLE;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            cnt_n = '0;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // NACK and watchdog expiry share one exit: release both lines, flag error
    if (abort) begin
      c_oe_n  = 1'b0;
      d_oe_n  = 1'b0;
      busy_n  = 1'b0;
      error_n = 1'b1;
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wdog     <= '0;
      n        <= '0;
      data     <= '0;
      par      <= 1'b0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wdog     <= wdog_n;
      n        <= n_n;
      data     <= data_n;
      par      <= par_n;
      ps2c_oe  <= c_oe_n;
      ps2d_oe  <= d_oe_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
      tx_error <= error_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model that clocks every
// 40 cycles, captures host bits on rising edges and ACKs or NACKs.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       tx_busy, tx_done, tx_error;

  logic bfm_c  = 1'b1;
  logic bfm_d  = 1'b1;
  logic glitch = 1'b0;

  // Open-drain wired-AND of host and device
  assign ps2c_in = bfm_c & ~glitch & ~ps2c_oe;
  assign ps2d_in = bfm_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(400),
    .FILTER_LEN    (2),
    .IDLE_CYCLES   (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   done_cnt, err_cnt, err_cycle, inh_len, rel_cycle;
  logic done_busy, err_busy, busy_t1;
  logic cap [0:10];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "bench stopped");
  end

  // Advance to the next falling clock edge and tally output pulses
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (tx_done) begin
      done_cnt++;
      done_busy = tx_busy;
    end
    if (tx_error) begin
      err_cnt++;
      err_cycle = cycle;
      err_busy  = tx_busy;
    end
  endtask

  task automatic clear_mon();
    done_cnt  = 0;
    err_cnt   = 0;
    err_cycle = 0;
    done_busy = 1'bx;
    err_busy  = 1'bx;
  endtask

  // Pulse tx_start, then measure how long the host holds the clock low
  task automatic send_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    busy_t1  = tx_busy;
    inh_len  = 0;
    while (ps2c_oe && inh_len < 100) begin
      inh_len++;
      tick();
    end
    rel_cycle = cycle;
  endtask

  // Device model: 20 cycles low, 20 high; returns right after the last rise
  task automatic bfm(input int edges, input bit ack, input int poke_edge, input int glitch_edge);
    repeat (10) tick();
    cap[0] = ps2d_in;
    for (int e = 1; e <= edges; e++) begin
      bfm_c = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (e == poke_edge && i == 5) begin
          tx_data  = 8'h12;
          tx_start = 1'b1;
        end
        tick();
        tx_start = 1'b0;
      end
      bfm_c = 1'b1;
      if (e <= 10) cap[e] = ps2d_in;
      if (e < edges) begin
        for (int i = 0; i < 20; i++) begin
          if (e == 10 && ack && i == 10) bfm_d = 1'b0;
          if (e == glitch_edge && i == 8) glitch = 1'b1;
          tick();
          glitch = 1'b0;
        end
      end
    end
    bfm_d = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && tx_busy; i++) tick();
  endtask

  function automatic logic [7:0] cap_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cap[i+1];
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (ps2c_oe !== 1'b0) begin errors++; $display("FAIL reset_ps2c_oe: got %b want 0", ps2c_oe); end
    checks++; if (ps2d_oe !== 1'b0) begin errors++; $display("FAIL reset_ps2d_oe: got %b want 0", ps2d_oe); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
    checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", tx_error); end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_send_ack(input logic [7:0] d, input logic par_exp, input string name);
    clear_mon();
    send_start(d);
    checks++; if (busy_t1 !== 1'b1) begin errors++; $display("FAIL %s busy_t1: got %b want 1", name, busy_t1); end
    checks++; if (inh_len != 20) begin errors++; $display("FAIL %s inhibit_len: got %0d want 20", name, inh_len); end
    bfm(11, 1'b1, 0, 0);
    wait_idle();
    checks++; if (cap[0] !== 1'b0) begin errors++; $display("FAIL %s start_bit: got %b want 0", name, cap[0]); end
    checks++; if (cap_byte() !== d) begin errors++; $display("FAIL %s data: got %h want %h", name, cap_byte(), d); end
    checks++; if (cap[9] !== par_exp) begin errors++; $display("FAIL %s parity: got %b want %b", name, cap[9], par_exp); end
    checks++; if (cap[10] !== 1'b1) begin errors++; $display("FAIL %s stop_bit: got %b want 1", name, cap[10]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL %s error_count: got %0d want 0", name, err_cnt); end
    checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, done_busy); end
    repeat (5) tick();
  endtask

  task automatic test_nack();
    clear_mon();
    send_start(8'h00);
    bfm(11, 1'b0, 0, 0);
    repeat (5) tick();
    checks++; if (cap_byte() !== 8'h00) begin errors++; $display("FAIL nack data: got %h want 00", cap_byte()); end
    checks++; if (cap[9] !== 1'b1) begin errors++; $display("FAIL nack parity: got %b want 1", cap[9]); end
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL nack error_count: got %0d want 1", err_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL nack done_count: got %0d want 0", done_cnt); end
    checks++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin errors++; $display("FAIL nack oe: got %b want 00", {ps2c_oe, ps2d_oe}); end
    checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL nack busy_at_error: got %b want 0", err_busy); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_start(8'h5A);
    for (int i = 0; i < 450 && err_cnt == 0; i++) tick();
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout error_count: got %0d want 1", err_cnt); end
    checks++; if (err_cycle - rel_cycle != 400) begin errors++; $display("FAIL timeout latency: got %0d want 400", err_cycle - rel_cycle); end
    checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL timeout busy_at_error: got %b want 0", err_busy); end
    checks++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin errors++; $display("FAIL timeout oe: got %b want 00", {ps2c_oe, ps2d_oe}); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL timeout done_count: got %0d want 0", done_cnt); end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_start(8'hAA);
    bfm(5, 1'b0, 0, 0);
    reset = 1'b1;
    tick();
    checks++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin errors++; $display("FAIL midreset oe: got %b want 00", {ps2c_oe, ps2d_oe}); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", tx_busy); end
    checks++; if (done_cnt + err_cnt != 0) begin errors++; $display("FAIL midreset pulses: got %0d want 0", done_cnt + err_cnt); end
    reset = 1'b0;
    repeat (5) tick();
    test_send_ack(8'h55, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_start(8'hED);
    bfm(11, 1'b1, 3, 6);
    wait_idle();
    checks++; if (cap_byte() !== 8'hED) begin errors++; $display("FAIL b2b first_data: got %h want ed", cap_byte()); end
    checks++; if (cap[9] !== 1'b1) begin errors++; $display("FAIL b2b first_parity: got %b want 1", cap[9]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b first_done: got %0d want 1", done_cnt); end
    tick();
    send_start(8'h3C);
    checks++; if (busy_t1 !== 1'b1) begin errors++; $display("FAIL b2b accept_busy: got %b want 1", busy_t1); end
    checks++; if (inh_len != 20) begin errors++; $display("FAIL b2b inhibit_len: got %0d want 20", inh_len); end
    bfm(11, 1'b1, 0, 0);
    wait_idle();
    checks++; if (cap_byte() !== 8'h3C) begin errors++; $display("FAIL b2b second_data: got %h want 3c", cap_byte()); end
    checks++; if (cap[9] !== 1'b1) begin errors++; $display("FAIL b2b second_parity: got %b want 1", cap[9]); end
    checks++; if (done_cnt != 2 || err_cnt != 0) begin errors++; $display("FAIL b2b pulses: got done=%0d err=%0d want done=2 err=0", done_cnt, err_cnt); end
  endtask

  initial begin
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    clear_mon();
    test_reset();
    test_send_ack(8'hED, 1'b1, "send_ed");
    test_send_ack(8'hF4, 1'b0, "send_f4");
    test_nack();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
